// File: rtl/axi_wr_arb_mux_if.sv
// axi_wr_arb_mux_if: NUM master-side AW/W channel pairs plus the single merged slave-side AW/W pair
interface axi_wr_arb_mux_if #(
  parameter int NUM  = 4,
  parameter int IDW  = 4,
  parameter int AW   = 32,
  parameter int DW   = 64,
  parameter int SELW = $clog2(NUM)
);
  logic [NUM-1:0]      m_awvalid;
  logic [NUM-1:0]      m_awready;
  logic [NUM*IDW-1:0]  m_awid;
  logic [NUM*AW-1:0]   m_awaddr;
  logic [NUM*8-1:0]    m_awlen;
  logic [NUM-1:0]      m_wvalid;
  logic [NUM-1:0]      m_wready;
  logic [NUM*DW-1:0]   m_wdata;
  logic [NUM-1:0]      m_wlast;
  logic                s_awvalid;
  logic                s_awready;
  logic [SELW+IDW-1:0] s_awid;
  logic [AW-1:0]       s_awaddr;
  logic [7:0]          s_awlen;
  logic                s_wvalid;
  logic                s_wready;
  logic [DW-1:0]       s_wdata;
  logic                s_wlast;
  modport slave (
    input  m_awvalid, m_awid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, s_awready, s_wready,
    output m_awready, m_wready, s_awvalid, s_awid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast
  );
  modport master (
    output m_awvalid, m_awid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, s_awready, s_wready,
    input  m_awready, m_wready, s_awvalid, s_awid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast
  );
endinterface

// File: rtl/axi_wr_arb_mux.sv
// axi_wr_arb_mux: round-robin merge of NUM AW/W master pairs onto one slave pair; ports clk, rst_n, bus (slave modport), busy, err_len
module axi_round_robin #(
  parameter int WID = 4,
  parameter int PW  = $clog2(WID)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WID-1:0] req_i,
  output logic [WID-1:0] grant_o,
  output logic [PW-1:0]  pos_o
);
  logic [PW-1:0] ptr_q;
  logic          found;
  int            idx;
  always_comb begin
    pos_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < WID; k++) begin
      idx = (int'(ptr_q) + k) % WID;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pos_o = PW'(idx);
      end
    end
    grant_o = found ? WID'(1) << pos_o : '0;
  end
  // ptr_q holds the first index to search, i.e. one past the last winner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else if (found) ptr_q <= (int'(pos_o) == WID - 1) ? '0 : pos_o + PW'(1);
endmodule

module axi_wr_arb_mux #(
  parameter int NUM  = 4,
  parameter int IDW  = 4,
  parameter int AW   = 32,
  parameter int DW   = 64,
  parameter int SELW = $clog2(NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_wr_arb_mux_if.slave   bus,
  output logic              busy,
  output logic              err_len
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, pos;
  logic [7:0]      cnt_q, cnt_d;
  logic [NUM-1:0]  req, grant;
  logic            aw_hs, w_beat;
  // requests only reach the arbiter in IDLE so its pointer moves once per grant
  assign req = (state_q == IDLE) ? bus.m_awvalid : '0;
  axi_round_robin #(.WID(NUM), .PW(SELW)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .grant_o (grant),
    .pos_o   (pos)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    bus.s_awvalid = state_q == ADDR;
    bus.s_awid    = {sel_q, bus.m_awid[sel_q*IDW +: IDW]};
    bus.s_awaddr  = bus.m_awaddr[sel_q*AW +: AW];
    bus.s_awlen   = bus.s_awvalid ? bus.m_awlen[sel_q*8 +: 8] : '0;
    bus.m_awready = bus.s_awvalid ? NUM'(bus.s_awready) << sel_q : '0;
    bus.s_wvalid  = state_q == DATA && bus.m_wvalid[sel_q];
    bus.s_wdata   = bus.s_wvalid ? bus.m_wdata[sel_q*DW +: DW] : '0;
    bus.s_wlast   = bus.s_wvalid && bus.m_wlast[sel_q];
    bus.m_wready  = (state_q == DATA) ? NUM'(bus.s_wready) << sel_q : '0;
    aw_hs         = bus.s_awvalid && bus.s_awready;
    w_beat        = bus.s_wvalid && bus.s_wready;
    // cnt_q reaches 0 on the beat that should carry wlast and saturates there
    err_len       = w_beat && (bus.s_wlast ? cnt_q != '0 : cnt_q == '0);
    busy          = state_q != IDLE;
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    if (state_q == IDLE && |grant) begin
      sel_d   = pos;
      state_d = ADDR;
    end
    if (aw_hs) begin
      cnt_d   = bus.m_awlen[sel_q*8 +: 8];
      state_d = DATA;
    end
    if (w_beat) begin
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 8'd1;
      state_d = bus.s_wlast ? IDLE : state_q;
    end
  end
endmodule
